// File: rtl/div_pipe_sched_if.sv
`default_nettype none
// ------------------------------------------------------------------
// div_pipe_sched_if : requester-side operand/result bus of the shared
//                     divider scheduler
// Rev 1.0
// ------------------------------------------------------------------
interface div_pipe_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 32
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*DW-1:0] req_a;
  logic [NUM_REQ*DW-1:0] req_b;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [DW-1:0]         rsp_z;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_z
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_z
  );
endinterface
`default_nettype wire

// File: rtl/div_pipe_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// div_pipe_sched : round-robin scheduler sharing one pipelined FP
//                  divider, with a shadow tag pipe routing quotients
// Rev 1.0
// ------------------------------------------------------------------
module div_pipe_sched #(
  parameter  int NUM_REQ     = 4,
  parameter  int sig_width   = 23,
  parameter  int exp_width   = 8,
  parameter  int DIV_LATENCY = 6,
  localparam int DW          = sig_width + exp_width + 1,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  div_pipe_sched_if.slave req_if,
  output logic [DW-1:0]   div_a,
  output logic [DW-1:0]   div_b,
  output logic            div_ab_valid,
  input  logic [DW-1:0]   div_z,
  input  logic            div_z_valid,
  output logic            busy,
  output logic            err
);

  localparam int IDX_W = ID_W + 1;

  logic [ID_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]                    div_a_q, div_a_d;
  logic [DW-1:0]                    div_b_q, div_b_d;
  logic                             div_ab_valid_q, div_ab_valid_d;
  logic [ID_W-1:0]                  issue_id_q, issue_id_d;
  logic [DIV_LATENCY-1:0]           tag_v_q, tag_v_d;
  logic [DIV_LATENCY-1:0][ID_W-1:0] tag_id_q, tag_id_d;
  logic [NUM_REQ-1:0]               rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]                    rsp_z_q, rsp_z_d;
  logic                             err_q, err_d;

  logic             gnt_found;
  logic [ID_W-1:0]  gnt_id;
  logic [IDX_W-1:0] scan_idx;
  logic             tail_v;
  logic [ID_W-1:0]  tail_id;
  logic             deliver;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + IDX_W'(k);
      if (scan_idx >= IDX_W'(NUM_REQ)) begin
        scan_idx = scan_idx - IDX_W'(NUM_REQ);
      end
      if (!gnt_found && en && req_if.req_valid[scan_idx[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_idx[ID_W-1:0];
      end
    end
  end

  assign req_if.req_ready = gnt_found ? (NUM_REQ'(1) << gnt_id) : '0;

  assign tail_v  = tag_v_q[DIV_LATENCY-1];
  assign tail_id = tag_id_q[DIV_LATENCY-1];
  assign deliver = div_z_valid & tail_v;

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    div_a_d        = div_a_q;
    div_b_d        = div_b_q;
    issue_id_d     = issue_id_q;
    div_ab_valid_d = gnt_found;
    if (gnt_found) begin
      rr_ptr_d   = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      div_a_d    = req_if.req_a[int'(gnt_id)*DW +: DW];
      div_b_d    = req_if.req_b[int'(gnt_id)*DW +: DW];
      issue_id_d = gnt_id;
    end

    // Stage 0 captures the issue registers, so the tail meets div_z_valid.
    tag_v_d     = '0;
    tag_id_d    = '0;
    tag_v_d[0]  = div_ab_valid_q;
    tag_id_d[0] = issue_id_q;
    for (int s = 1; s < DIV_LATENCY; s++) begin
      tag_v_d[s]  = tag_v_q[s-1];
      tag_id_d[s] = tag_id_q[s-1];
    end

    rsp_valid_d = deliver ? (NUM_REQ'(1) << tail_id) : '0;
    rsp_z_d     = deliver ? div_z : rsp_z_q;
    err_d       = err_q | (div_z_valid ^ tail_v);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      div_a_q        <= '0;
      div_b_q        <= '0;
      div_ab_valid_q <= 1'b0;
      issue_id_q     <= '0;
      tag_v_q        <= '0;
      tag_id_q       <= '0;
      rsp_valid_q    <= '0;
      rsp_z_q        <= '0;
      err_q          <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      div_a_q        <= div_a_d;
      div_b_q        <= div_b_d;
      div_ab_valid_q <= div_ab_valid_d;
      issue_id_q     <= issue_id_d;
      tag_v_q        <= tag_v_d;
      tag_id_q       <= tag_id_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_z_q        <= rsp_z_d;
      err_q          <= err_d;
    end
  end

  assign div_a            = div_a_q;
  assign div_b            = div_b_q;
  assign div_ab_valid     = div_ab_valid_q;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_z     = rsp_z_q;
  assign err              = err_q;
  assign busy             = div_ab_valid_q | (|tag_v_q) | (|rsp_valid_q);

endmodule
`default_nettype wire

// File: doc/div_pipe_sched.md
Name: div_pipe_sched

Overview:
- Round-robin scheduler sharing one pipelined FP divider (div_pipe) among NUM_REQ requesters, e.g. the RMSnorm lanes.
- Each cycle it accepts at most one {a,b} operand pair and issues it to the divider with an ID tag.
- The tag travels through a shadow pipeline matched to the divider latency.
- Each quotient is returned to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- sig_width, 23, divider significand width.
- exp_width, 8, divider exponent width; DW = sig_width+exp_width+1.
- DIV_LATENCY, 6, divider latency in cycles: div_ab_valid high in cycle k gives div_z_valid in cycle k+DIV_LATENCY. Must equal in_reg+out_reg+stages-1 of the instance.
- ID_W, derived, $clog2(NUM_REQ).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- en  in  1  grant enable; when low, no new grants and in-flight operations drain.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_a  in  NUM_REQ*DW  packed dividends; requester i occupies [i*DW +: DW].
- req_b  in  NUM_REQ*DW  packed divisors.
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- div_a  out  DW  registered dividend to the divider.
- div_b  out  DW  registered divisor to the divider.
- div_ab_valid  out  1  registered issue strobe.
- div_z  in  DW  divider quotient.
- div_z_valid  in  1  divider result strobe.
- rsp_valid  out  NUM_REQ  registered one-hot result strobe.
- rsp_z  out  DW  registered quotient, shared by all requesters.
- busy  out  1  high if any operation is in flight.
- err  out  1  sticky tag/result misalignment flag.

Behaviour:
- Reset: asynchronous, active-low. Clock is clk, reset is rst_n. All outputs reset to 0, rr_ptr resets to 0, and every tag-pipe valid bit resets to 0.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ.
  - The first set index g gets req_ready[g]=1. At most one bit of req_ready is set.
  - req_ready is all-zero when en=0 or no request is valid.
  - req_ready depends only on req_valid, en and rr_ptr; there is no combinational path from div_z_valid.
- Handshake: a transfer occurs when req_valid[i]&req_ready[i]. A requester holds req_valid and its operands stable until accepted.
- Pointer update on a grant to g: rr_ptr <= (g+1) mod NUM_REQ. Without a grant, rr_ptr holds.
- Issue: acceptance in cycle c gives div_a/div_b = operands of g and div_ab_valid=1 in cycle c+1. With no acceptance, div_ab_valid=0 and div_a/div_b hold their last values.
- Throughput: one issue per cycle; back-to-back grants are allowed, including to the same requester when it is the only one valid.
- Tag pipe:
  - DIV_LATENCY stages of {v,id}. Stage 0 loads {div_ab_valid, issued id} in the same cycle div_ab_valid is driven.
  - Each stage shifts every cycle, so the tail is aligned with div_z_valid in cycle c+1+DIV_LATENCY.
- Return:
  - When div_z_valid & tail.v: next cycle rsp_valid[tail.id]=1 and rsp_z=div_z.
  - Otherwise rsp_valid=0 and rsp_z holds.
  - Total latency from acceptance to rsp_valid is DIV_LATENCY+2 cycles (8 at default).
- No backpressure on responses: each requester must accept its rsp_valid pulse.
- Ordering: results return in issue order. Per requester, responses come back in the same order as its requests.
- Error: err is set if div_z_valid != tail.v in any cycle. err stays set until reset, and the response is still delivered only when both div_z_valid and tail.v are high.
- busy = div_ab_valid | OR of all tag-pipe v bits | rsp_valid-pending stage.
- en deasserted mid-stream: in-flight operations complete and deliver normally; rr_ptr is frozen.
- Reset mid-operation: all in-flight tags are discarded and no rsp_valid appears after reset release. The divider must be reset by the same rst_n.
- NaN, infinity and divide-by-zero results pass through unmodified.

Test Plan:
- Single requester:
  - Stimulus: req 0, a=0x40C00000 (6.0), b=0x40000000 (2.0), accepted in cycle c.
  - Required: div_ab_valid in cycle c+1; rsp_valid=4'b0001 and rsp_z=0x40400000 (3.0) in cycle c+8; busy low from cycle c+9.
- Full contention:
  - Stimulus: all 4 req_valid held high with distinct operands for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3, one per cycle; rsp_valid order matches; every quotient within 1e-5 relative of the shortreal model.
- Pointer wrap and skip:
  - Stimulus: rr_ptr=3 with only req 1 and req 3 valid.
  - Required: grant 3, then 1, then 3; rr_ptr values go 0, then 2, then 0.
- Bubbles and en:
  - Stimulus: 7 back-to-back requests, one idle cycle, 2 more; en low for 3 cycles mid-burst.
  - Required: no grants while en=0; all 9 responses delivered, with a gap exactly where issue stopped.
- Reset mid-flight:
  - Stimulus: rst_n low for 2 cycles, 3 cycles after issuing 4 operations.
  - Required: all outputs 0 during reset; zero rsp_valid pulses afterwards; err=0.
- Misalignment:
  - Stimulus: force div_z_valid=1 with the tag pipe empty.
  - Required: err=1 the next cycle and sticky; rsp_valid stays 0.
